irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
Interrupt controller sitting directly upstream of the control FSM. It synchronises NUM_SRC external interrupt lines and holds pending and mask state. It drives the single irq request into the FSM and consumes the FSM's iack to latch which source is in service. Software reaches it through a small word-addressed register port on the data bus.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..32); index 0 = highest priority
SYNC_STAGES, 2, flip-flop depth of the input synchroniser (>=2)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
ext_irq  input  NUM_SRC  raw asynchronous interrupt lines
iack  input  1  interrupt acknowledge from control FSM; high from IRQ entry until RET
wr_en  input  1  register write strobe
addr  input  2  register select: 0 PEND, 1 MASK, 2 EDGE, 3 CAUSE
wdata  input  32  write data
rdata  output  32  combinational read data for addr
irq  output  1  registered interrupt request to control FSM
irq_id  output  5  id of the in-service source, valid while cause_valid
cause_valid  output  1  an identified source is in service

Behaviour:
- Reset (asynchronous, rst=1): all synchroniser flops, PEND, MASK, EDGE, iack_q, irq_id, cause_valid = 0; state = IDLE; irq = 0.
- Per source: SYNC_STAGES-flop synchroniser, then prev-value flop. rise = sync & ~prev.
- EDGE[i]=1 (edge mode): PEND[i] is set on rise and stays set until cleared.
- EDGE[i]=0 (level mode): PEND[i] is the synchronised level. It is not stored and cannot be cleared by software.
- eligible = PEND & MASK. any = |eligible. sel = lowest set index of eligible.
- iack_q registers iack. ack_rise = iack & ~iack_q. ack_fall = ~iack & iack_q.
- FSM states: IDLE, REQ, SERVICE. irq = 1 only in REQ; irq is a registered decode.
  - IDLE: if any, go to REQ; else stay.
  - REQ, ack_rise: go to SERVICE. Latch irq_id = sel and cause_valid = any. If sel is edge mode, clear PEND[sel].
  - REQ, ~any and no ack_rise: return to IDLE (request withdrawn).
  - SERVICE: irq = 0 regardless of new pending. On ack_fall go to IDLE and clear cause_valid; irq_id holds its value.
  - ack_rise outside REQ: ignored.
- Spurious acknowledge: if ack_rise occurs in REQ while ~any, go to SERVICE with cause_valid = 0 and no PEND change.
- Latency with SYNC_STAGES=2: ext_irq sampled high at edge 1 gives synced at edge 2, PEND at edge 3, and irq=1 after edge 4.
- Re-request: earliest irq re-assertion is 1 cycle after the ack_fall edge.
- Register writes, applied on the clk edge with wr_en:
  - PEND is W1C, for edge-mode bits only.
  - MASK and EDGE are plain writes.
  - CAUSE is read-only; writes are ignored.
- Bits >= NUM_SRC read 0 and ignore writes.
- CAUSE read format: {cause_valid at bit 31, zeros, irq_id[4:0]}.
- Simultaneous events:
  - Set and clear on the same PEND bit in one cycle (rise vs W1C, or rise vs ack clear): set wins.
  - MASK write in the same cycle as ack_rise: sel uses the pre-write MASK.
  - Changing EDGE[i] from 0 to 1 leaves PEND[i] = 0 until the next rise.

Decomposition:
- Shared defines file gets: register addresses IRQ_PEND/MASK/EDGE/CAUSE, state encodings IRQ_IDLE/REQ/SERVICE, and the CAUSE valid-bit position.
- One sub-module, irq_sync_edge, instantiated per source: parameter SYNC_STAGES, ports clk, rst, in, sync, rise.

Test Plan:
- Reset mid-REQ: assert rst while irq=1 -> irq, PEND, MASK, cause_valid all 0 on the same cycle, with no clock edge needed.
- Single edge source: EDGE=0x01, MASK=0x01, pulse ext_irq[0] for 1 cycle -> irq=1 after 4 edges. Raise iack -> irq=0, irq_id=0, cause_valid=1, PEND=0x00. Drop iack -> cause_valid=0 one cycle later.
- Priority: EDGE=0xFF, MASK=0xFF, rises on sources 5 and 2 in the same cycle -> irq_id=2 on first ack, PEND=0x20 stays. After iack falls, irq re-asserts and the second ack gives irq_id=5.
- Level source: EDGE=0x00, MASK=0x08, hold ext_irq[3]=1 -> irq_id=3. Writing PEND=0x08 has no effect. After deasserting ext_irq[3] for 3 cycles, PEND reads 0x00.
- Withdrawal and spurious ack: in REQ, write MASK=0 -> irq falls next cycle and state returns to IDLE. Separately, force ack_rise with eligible=0 in REQ -> cause_valid=0, PEND unchanged.
- Set beats clear: rise on source 1 in the same cycle as a W1C write of 0x02 -> PEND[1] reads 1 afterwards.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared register map, FSM state encoding and CAUSE layout for the interrupt controller.
// No logic; constants and types only.
// Imported by irq_ctrl and its sub-modules.
package irq_ctrl_pkg;

  localparam logic [1:0] IRQ_PEND  = 2'd0;
  localparam logic [1:0] IRQ_MASK  = 2'd1;
  localparam logic [1:0] IRQ_EDGE  = 2'd2;
  localparam logic [1:0] IRQ_CAUSE = 2'd3;

  localparam int CAUSE_VLD_BIT = 31;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line synchroniser with rising-edge detect on the synchronised value.
// Latency: SYNC_STAGES cycles to sync, rise valid in the same cycle as sync.
// No backpressure; free-running sampler.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic sync,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   prev;

  // Shift the raw line through the synchroniser and keep the last synced value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= '0;
      prev    <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], in};
      prev    <= sync_ff[SYNC_STAGES-1];
    end
  end

  assign sync = sync_ff[SYNC_STAGES-1];
  assign rise = sync & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises sources, holds PEND/MASK/EDGE, requests the FSM and tracks service.
// Latency: raw line to irq is SYNC_STAGES+2 edges for edge-mode sources.
// No backpressure; irq holds in REQ until the FSM acknowledges or the request is withdrawn.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] ext_irq,
  input  logic               iack,
  input  logic               wr_en,
  input  logic [1:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               irq,
  output logic [4:0]         irq_id,
  output logic               cause_valid
);

  logic [NUM_SRC-1:0] sync, rise;
  logic [NUM_SRC-1:0] pend_q, pend, mask_q, edge_q, elig;
  logic [NUM_SRC-1:0] w1c, ack_clr;
  logic [4:0]         sel;
  logic               any, iack_q, ack_rise, ack_fall, take_ack;
  irq_state_t         state;
  logic               unused_wdata;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .in   (ext_irq[g]),
      .sync (sync[g]),
      .rise (rise[g])
    );
  end

  // Level-mode bits are the live synchronised line; edge-mode bits come from storage.
  assign pend     = (pend_q & edge_q) | (sync & ~edge_q);
  assign elig     = pend & mask_q;
  assign any      = |elig;
  assign ack_rise = iack & ~iack_q;
  assign ack_fall = ~iack & iack_q;
  assign take_ack = (state == IRQ_REQ) && ack_rise && any;
  assign w1c      = (wr_en && addr == IRQ_PEND) ? (wdata[NUM_SRC-1:0] & edge_q) : '0;
  assign unused_wdata = ^wdata;

  // Lowest eligible index wins; scanning downward leaves the smallest index last.
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) sel = 5'(i);
    end
  end

  // The serviced source is cleared only if it is edge mode.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_clr[i] = take_ack && (sel == 5'(i)) && edge_q[i];
    end
  end

  // Register file: clears applied first so a same-cycle rise wins; storage forced to 0 in level mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      mask_q <= '0;
      edge_q <= '0;
      iack_q <= 1'b0;
    end else begin
      pend_q <= ((pend_q & ~w1c & ~ack_clr) | rise) & edge_q;
      iack_q <= iack;
      if (wr_en && addr == IRQ_MASK) mask_q <= wdata[NUM_SRC-1:0];
      if (wr_en && addr == IRQ_EDGE) edge_q <= wdata[NUM_SRC-1:0];
    end
  end

  // Request/service FSM with irq registered as the decode of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IRQ_IDLE;
      irq         <= 1'b0;
      irq_id      <= '0;
      cause_valid <= 1'b0;
    end else begin
      case (state)
        IRQ_IDLE: begin
          if (any) begin
            state <= IRQ_REQ;
            irq   <= 1'b1;
          end else begin
            irq   <= 1'b0;
          end
        end
        IRQ_REQ: begin
          if (ack_rise) begin
            state       <= IRQ_SERVICE;
            irq         <= 1'b0;
            irq_id      <= sel;
            cause_valid <= any;
          end else if (!any) begin
            state <= IRQ_IDLE;
            irq   <= 1'b0;
          end
        end
        IRQ_SERVICE: begin
          irq <= 1'b0;
          if (ack_fall) begin
            state       <= IRQ_IDLE;
            cause_valid <= 1'b0;
          end
        end
        default: begin
          state <= IRQ_IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

  // Combinational register read; unimplemented bits read zero.
  always_comb begin
    rdata = '0;
    case (addr)
      IRQ_PEND:  rdata[NUM_SRC-1:0] = pend;
      IRQ_MASK:  rdata[NUM_SRC-1:0] = mask_q;
      IRQ_EDGE:  rdata[NUM_SRC-1:0] = edge_q;
      default: begin
        rdata[CAUSE_VLD_BIT] = cause_valid;
        rdata[4:0]           = irq_id;
      end
    endcase
  end

endmodule
